// File: rtl/mesi_isc_pkg.sv
// Shared MESI ISC types: coherence-bus commands, broadcast types, controller states.
// Widths here set the default widths of the broadcast controller and its interface.
package mesi_isc_pkg;

  localparam int NUM_CPUS         = 4;
  localparam int CPU_ID_WIDTH     = 2;
  localparam int CBUS_CMD_W       = 3;
  localparam int BROAD_TYPE_W     = 2;
  localparam int BROAD_ID_W       = 5;
  localparam int ADDR_W           = 32;

  typedef enum logic [CBUS_CMD_W-1:0] {
    CBUS_NOP      = 3'd0,
    CBUS_WR_SNOOP = 3'd1,
    CBUS_RD_SNOOP = 3'd2,
    CBUS_EN_WR    = 3'd3,
    CBUS_EN_RD    = 3'd4
  } cbus_cmd_e;

  typedef enum logic [BROAD_TYPE_W-1:0] {
    BT_NOP = 2'd0,
    BT_WR  = 2'd1,
    BT_RD  = 2'd2
  } bcast_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SNOOP  = 2'd1,
    ST_ENABLE = 2'd2
  } bcast_state_e;

endpackage

// File: rtl/mesi_cbus_bcast_ctrl_if.sv
// Broadcast-queue handshake plus the four per-CPU coherence buses.
// master: the broadcast controller; slave: the queue and CPU side.
interface mesi_cbus_bcast_ctrl_if
  import mesi_isc_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH   = CBUS_CMD_W,
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_W,
  parameter int BROAD_ID_WIDTH   = BROAD_ID_W
) ();

  logic                                      bcast_valid_i;
  logic                                      bcast_ready_o;
  logic [BROAD_TYPE_WIDTH-1:0]               bcast_type_i;
  logic [CPU_ID_WIDTH-1:0]                   bcast_cpu_id_i;
  logic [BROAD_ID_WIDTH-1:0]                 bcast_id_i;
  logic [ADDR_WIDTH-1:0]                     bcast_addr_i;
  logic [ADDR_WIDTH-1:0]                     cbus_addr_o;
  logic [NUM_CPUS-1:0][CBUS_CMD_WIDTH-1:0]   cbus_cmd_o;
  logic [NUM_CPUS-1:0]                       cbus_ack_i;
  logic                                      bcast_done_o;
  logic [BROAD_ID_WIDTH-1:0]                 bcast_done_id_o;

  modport master (
    input  bcast_valid_i, bcast_type_i, bcast_cpu_id_i, bcast_id_i, bcast_addr_i, cbus_ack_i,
    output bcast_ready_o, cbus_addr_o, cbus_cmd_o, bcast_done_o, bcast_done_id_o
  );

  modport slave (
    output bcast_valid_i, bcast_type_i, bcast_cpu_id_i, bcast_id_i, bcast_addr_i, cbus_ack_i,
    input  bcast_ready_o, cbus_addr_o, cbus_cmd_o, bcast_done_o, bcast_done_id_o
  );

endinterface

// File: rtl/mesi_cbus_bcast_ctrl.sv
// One broadcast at a time: snoop the three other CPUs, then enable the source; min 3 cycles/broadcast.
// Ready only in IDLE; waits indefinitely for acks, acks from uncommanded CPUs are ignored.
module mesi_cbus_bcast_ctrl
  import mesi_isc_pkg::*;
#(
  parameter int CBUS_CMD_WIDTH   = CBUS_CMD_W,
  parameter int ADDR_WIDTH       = ADDR_W,
  parameter int BROAD_TYPE_WIDTH = BROAD_TYPE_W,
  parameter int BROAD_ID_WIDTH   = BROAD_ID_W
) (
  input logic                    clk,
  input logic                    rst,
  mesi_cbus_bcast_ctrl_if.master bus
);

  bcast_state_e                            state;
  logic [NUM_CPUS-1:0]                     pend;
  logic [BROAD_TYPE_WIDTH-1:0]             type_q;
  logic [CPU_ID_WIDTH-1:0]                 src_q;
  logic [BROAD_ID_WIDTH-1:0]               id_q;
  logic [ADDR_WIDTH-1:0]                   addr_q;
  logic [NUM_CPUS-1:0][CBUS_CMD_WIDTH-1:0] cmd_q;
  logic                                    done_q;
  logic [BROAD_ID_WIDTH-1:0]               done_id_q;

  logic                      is_wr_in;
  logic                      is_rd_in;
  logic [NUM_CPUS-1:0]       pend_in;
  logic [NUM_CPUS-1:0]       pend_left;
  logic [NUM_CPUS-1:0]       src_onehot;
  logic [CBUS_CMD_WIDTH-1:0] snoop_in;
  logic [CBUS_CMD_WIDTH-1:0] snoop_q;
  logic [CBUS_CMD_WIDTH-1:0] en_q;
  logic [CBUS_CMD_WIDTH-1:0] nop_cmd;

  always_comb begin
    is_wr_in   = (bus.bcast_type_i == BT_WR);
    is_rd_in   = (bus.bcast_type_i == BT_RD);
    pend_in    = ~(NUM_CPUS'(1) << bus.bcast_cpu_id_i);
    // Only commanded CPUs can clear their bit, so stray acks fall out here.
    pend_left  = pend & ~bus.cbus_ack_i;
    src_onehot = NUM_CPUS'(1) << src_q;
    nop_cmd    = CBUS_CMD_WIDTH'(CBUS_NOP);
    snoop_in   = is_wr_in ? CBUS_CMD_WIDTH'(CBUS_WR_SNOOP) : CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
    snoop_q    = (type_q == BT_WR) ? CBUS_CMD_WIDTH'(CBUS_WR_SNOOP) : CBUS_CMD_WIDTH'(CBUS_RD_SNOOP);
    en_q       = (type_q == BT_WR) ? CBUS_CMD_WIDTH'(CBUS_EN_WR) : CBUS_CMD_WIDTH'(CBUS_EN_RD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pend      <= '0;
      type_q    <= '0;
      src_q     <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // NOP and reserved types are consumed without touching the buses.
          if (bus.bcast_valid_i && (is_wr_in || is_rd_in)) begin
            type_q <= bus.bcast_type_i;
            src_q  <= bus.bcast_cpu_id_i;
            id_q   <= bus.bcast_id_i;
            addr_q <= bus.bcast_addr_i;
            pend   <= pend_in;
            state  <= ST_SNOOP;
            for (int i = 0; i < NUM_CPUS; i++) begin
              cmd_q[i] <= pend_in[i] ? snoop_in : nop_cmd;
            end
          end
        end
        ST_SNOOP: begin
          pend <= pend_left;
          if (pend_left == '0) begin
            state <= ST_ENABLE;
            for (int i = 0; i < NUM_CPUS; i++) begin
              cmd_q[i] <= src_onehot[i] ? en_q : nop_cmd;
            end
          end else begin
            for (int i = 0; i < NUM_CPUS; i++) begin
              cmd_q[i] <= pend_left[i] ? snoop_q : nop_cmd;
            end
          end
        end
        ST_ENABLE: begin
          if ((bus.cbus_ack_i & src_onehot) != '0) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            done_q    <= 1'b1;
            done_id_q <= id_q;
          end
        end
        default: begin
          state <= ST_IDLE;
          cmd_q <= '0;
        end
      endcase
    end
  end

  assign bus.bcast_ready_o   = (state == ST_IDLE);
  assign bus.cbus_addr_o     = addr_q;
  assign bus.cbus_cmd_o      = cmd_q;
  assign bus.bcast_done_o    = done_q;
  assign bus.bcast_done_id_o = done_id_q;

endmodule

// File: tb/tb_mesi_cbus_bcast_ctrl.sv
// Directed scenarios followed by random broadcasts; a CPU model acks at random and predicts
// the bus commands, and a separate monitor pops the expected completion queue on every done pulse.
module tb_mesi_cbus_bcast_ctrl;
  import mesi_isc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesi_cbus_bcast_ctrl_if bif ();

  mesi_cbus_bcast_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  typedef struct {
    logic [1:0]  t;
    logic [1:0]  c;
    logic [4:0]  id;
    logic [31:0] a;
    int          acc_e;
  } txn_t;

  typedef struct {
    logic [4:0] id;
    int         due;
  } done_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  txn_t  exp_q[$];
  done_t done_q[$];

  logic        model_en = 1'b0;
  logic [3:0]  dir_ack  = 4'b0;
  logic [3:0]  mdl_ack  = 4'b0;
  logic        m_active = 1'b0;
  logic [3:0]  m_pend   = 4'b0;
  logic [31:0] m_addr   = 32'b0;
  txn_t        cur;

  assign bif.cbus_ack_i = model_en ? mdl_ack : dir_ack;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] cv(input int c3, input int c2, input int c1, input int c0);
    return {c3[2:0], c2[2:0], c1[2:0], c0[2:0]};
  endfunction

  task automatic drive(input logic [1:0] t, input logic [1:0] c, input logic [4:0] id,
                       input logic [31:0] a);
    bif.bcast_valid_i  = 1'b1;
    bif.bcast_type_i   = t;
    bif.bcast_cpu_id_i = c;
    bif.bcast_id_i     = id;
    bif.bcast_addr_i   = a;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] t, input logic [1:0] c, input logic [4:0] id,
                      input logic [31:0] a);
    int w = 0;
    drive(t, c, id, a);
    while (bif.bcast_ready_o !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("send_timeout", bif.bcast_ready_o, 1'b1);
    else if (t == 2'd1 || t == 2'd2) exp_q.push_back('{t: t, c: c, id: id, a: a, acc_e: cyc + 1});
    @(negedge clk);
    bif.bcast_valid_i = 1'b0;
  endtask

  // CPU-side reference: snoop the non-source CPUs until each acks, then enable the source.
  always @(negedge clk) begin : cpu_model
    logic [3:0]  ack;
    logic [11:0] ecmd;
    if (model_en && rst) begin
      if (!m_active && exp_q.size() > 0 && exp_q[0].acc_e <= cyc) begin
        cur      = exp_q.pop_front();
        m_active = 1'b1;
        m_pend   = 4'hF & ~(4'b1 << cur.c);
        m_addr   = cur.a;
      end
      ecmd = '0;
      if (m_active) begin
        for (int i = 0; i < 4; i++) begin
          if (m_pend != 4'b0) begin
            if (m_pend[i]) ecmd[3*i +: 3] = (cur.t == 2'd1) ? 3'd1 : 3'd2;
          end else if (i == int'(cur.c)) begin
            ecmd[3*i +: 3] = (cur.t == 2'd1) ? 3'd3 : 3'd4;
          end
        end
      end
      chk("rnd_cmd", bif.cbus_cmd_o, ecmd);
      chk("rnd_addr", bif.cbus_addr_o, m_addr);
      chk("rnd_ready", bif.bcast_ready_o, !m_active);
      ack = '0;
      for (int i = 0; i < 4; i++) begin
        if (ecmd[3*i +: 3] != 3'd0) ack[i] = ($urandom_range(0, 9) < 4);
        else                        ack[i] = ($urandom_range(0, 19) == 0);
      end
      if (m_active) begin
        if (m_pend != 4'b0) m_pend = m_pend & ~ack;
        else if (ack[cur.c]) begin
          done_q.push_back('{id: cur.id, due: cyc + 1});
          m_active = 1'b0;
        end
      end
      mdl_ack = ack;
    end
  end

  always @(negedge clk) begin : done_monitor
    done_t d;
    if (model_en && rst) begin
      if (bif.bcast_done_o === 1'b1) begin
        if (done_q.size() == 0) chk("done_unexpected", bif.bcast_done_o, 1'b0);
        else begin
          d = done_q.pop_front();
          chk("done_id", bif.bcast_done_id_o, d.id);
          chk("done_cycle", cyc, d.due);
        end
      end else if (done_q.size() > 0 && done_q[0].due < cyc) begin
        void'(done_q.pop_front());
        chk("done_missing", bif.bcast_done_o, 1'b1);
      end
    end
  end

  initial begin
    int w;
    rst = 1'b0;
    bif.bcast_valid_i = 1'b0;
    drive(2'd0, 2'd0, 5'd0, 32'd0);
    bif.bcast_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", bif.cbus_cmd_o, 12'd0);
    chk("rst_addr", bif.cbus_addr_o, 32'd0);
    chk("rst_done", bif.bcast_done_o, 1'b0);
    chk("rst_done_id", bif.bcast_done_id_o, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bif.bcast_ready_o, 1'b1);

    // basic write
    drive(2'd1, 2'd0, 5'd5, 32'h1000);
    @(negedge clk); bif.bcast_valid_i = 1'b0;
    chk("wr_snoop_cmd", bif.cbus_cmd_o, cv(1, 1, 1, 0));
    chk("wr_addr", bif.cbus_addr_o, 32'h1000);
    chk("wr_busy", bif.bcast_ready_o, 1'b0);
    dir_ack = 4'b1110;
    @(negedge clk);
    chk("wr_en_cmd", bif.cbus_cmd_o, cv(0, 0, 0, 3));
    dir_ack = 4'b0001;
    @(negedge clk);
    chk("wr_done", bif.bcast_done_o, 1'b1);
    chk("wr_done_id", bif.bcast_done_id_o, 5'd5);
    chk("wr_ready", bif.bcast_ready_o, 1'b1);
    chk("wr_idle_cmd", bif.cbus_cmd_o, 12'd0);
    dir_ack = 4'b0;
    @(negedge clk);
    chk("wr_done_pulse", bif.bcast_done_o, 1'b0);
    chk("wr_done_id_hold", bif.bcast_done_id_o, 5'd5);

    // staggered acks
    drive(2'd2, 2'd2, 5'd9, 32'h2340);
    @(negedge clk); bif.bcast_valid_i = 1'b0;
    chk("stg_c1", bif.cbus_cmd_o, cv(2, 0, 2, 2)); dir_ack = 4'b0001;
    @(negedge clk);
    chk("stg_c2", bif.cbus_cmd_o, cv(2, 0, 2, 0)); dir_ack = 4'b1000;
    @(negedge clk);
    chk("stg_c3", bif.cbus_cmd_o, cv(0, 0, 2, 0)); dir_ack = 4'b0000;
    @(negedge clk);
    chk("stg_c4", bif.cbus_cmd_o, cv(0, 0, 2, 0)); dir_ack = 4'b0010;
    @(negedge clk);
    chk("stg_c5", bif.cbus_cmd_o, cv(0, 4, 0, 0));
    chk("stg_c5_ready", bif.bcast_ready_o, 1'b0); dir_ack = 4'b0000;
    @(negedge clk);
    chk("stg_c6", bif.cbus_cmd_o, cv(0, 4, 0, 0));
    chk("stg_c6_ready", bif.bcast_ready_o, 1'b0); dir_ack = 4'b0100;
    @(negedge clk);
    chk("stg_done", bif.bcast_done_o, 1'b1);
    chk("stg_done_id", bif.bcast_done_id_o, 5'd9);
    chk("stg_ready", bif.bcast_ready_o, 1'b1); dir_ack = 4'b0;

    // spurious source ack during snoop
    drive(2'd1, 2'd1, 5'd3, 32'h3000);
    @(negedge clk); bif.bcast_valid_i = 1'b0;
    chk("spu_c1", bif.cbus_cmd_o, cv(1, 1, 0, 1)); dir_ack = 4'b0011;
    @(negedge clk);
    chk("spu_c2", bif.cbus_cmd_o, cv(1, 1, 0, 0)); dir_ack = 4'b1100;
    @(negedge clk);
    chk("spu_en", bif.cbus_cmd_o, cv(0, 0, 3, 0)); dir_ack = 4'b0010;
    @(negedge clk);
    chk("spu_done_id", bif.bcast_done_id_o, 5'd3);
    chk("spu_done", bif.bcast_done_o, 1'b1); dir_ack = 4'b0;

    // NOP type is consumed silently
    drive(2'd0, 2'd1, 5'd7, 32'hDEAD);
    chk("nop_ready_pre", bif.bcast_ready_o, 1'b1);
    @(negedge clk); bif.bcast_valid_i = 1'b0;
    chk("nop_ready", bif.bcast_ready_o, 1'b1);
    chk("nop_cmd", bif.cbus_cmd_o, 12'd0);
    chk("nop_done", bif.bcast_done_o, 1'b0);
    chk("nop_addr", bif.cbus_addr_o, 32'h3000);

    // reset mid-snoop
    drive(2'd1, 2'd0, 5'd4, 32'h4000);
    @(negedge clk); bif.bcast_valid_i = 1'b0;
    chk("rsn_cmd", bif.cbus_cmd_o, cv(1, 1, 1, 0));
    #2 rst = 1'b0;
    #1 chk("rsn_async_cmd", bif.cbus_cmd_o, 12'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rsn_ready", bif.bcast_ready_o, 1'b1);
    chk("rsn_done", bif.bcast_done_o, 1'b0);
    chk("rsn_done_id", bif.bcast_done_id_o, 5'd0);
    @(negedge clk);
    chk("rsn_done2", bif.bcast_done_o, 1'b0);

    // back-to-back with immediate acks
    drive(2'd1, 2'd1, 5'd1, 32'h5000);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) drive(2'd2, 2'd3, 5'd2, 32'h6000);
      if (k == 4) bif.bcast_valid_i = 1'b0;
      if (k == 3) begin
        chk("b2b_done1", bif.bcast_done_o, 1'b1);
        chk("b2b_id1", bif.bcast_done_id_o, 5'd1);
      end else if (k == 6) begin
        chk("b2b_done2", bif.bcast_done_o, 1'b1);
        chk("b2b_id2", bif.bcast_done_id_o, 5'd2);
      end else if (k < 6) begin
        chk("b2b_nodone", bif.bcast_done_o, 1'b0);
      end
      for (int i = 0; i < 4; i++) dir_ack[i] = (bif.cbus_cmd_o[i] != 3'd0);
    end
    dir_ack = 4'b0;

    // random traffic against the CPU model
    m_addr   = 32'h6000;
    model_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      int nn;
      nn = n;
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), nn[4:0], $urandom);
    end
    w = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0 || m_active) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", (w < 2000), 1'b1);
    @(negedge clk);
    model_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mesi_cbus_bcast_ctrl.md
# mesi_cbus_bcast_ctrl

Coherence-bus broadcast controller that sits directly downstream of the MESI ISC broadcast queue and drives the four per-CPU coherence buses. It takes one queued broadcast at a time (write or read miss from a source CPU), issues snoop commands to the three other CPUs, and collects their acks. It then grants the source CPU its enable command and reports completion by broadcast ID.

## Interface
Parameters:
- CBUS_CMD_WIDTH, 3, coherence-bus command width
- ADDR_WIDTH, 32, address width
- BROAD_TYPE_WIDTH, 2, broadcast type width
- BROAD_ID_WIDTH, 5, broadcast tag width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- bcast_valid_i  in  1  queue head valid
- bcast_ready_o  out  1  controller can accept
- bcast_type_i  in  BROAD_TYPE_WIDTH  NOP=0, WR=1, RD=2
- bcast_cpu_id_i  in  2  source CPU
- bcast_id_i  in  BROAD_ID_WIDTH  broadcast tag
- bcast_addr_i  in  ADDR_WIDTH  line address
- cbus_addr_o  out  ADDR_WIDTH  shared coherence-bus address
- cbus_cmd_o[3:0]  out  4×CBUS_CMD_WIDTH  per-CPU command: NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4
- cbus_ack_i  in  4  per-CPU ack, one-cycle pulse
- bcast_done_o  out  1  one-cycle completion pulse
- bcast_done_id_o  out  BROAD_ID_WIDTH  tag of completed broadcast

## Operation
- FSM states: IDLE, SNOOP, ENABLE.
- **IDLE:**
  - bcast_ready_o=1.
  - On valid&ready, capture type, cpu_id, id and addr.
  - Type WR or RD: go to SNOOP, with the pending mask set to all CPUs except the source.
  - Type NOP or 3: dropped; stay IDLE, no cbus activity, no done pulse.
- **SNOOP:**
  - cbus_cmd_o[i] = WR_SNOOP (type WR) or RD_SNOOP (type RD) for each i in the pending mask; NOP for all others.
  - An ack on cbus_ack_i[i] with mask bit i set clears that bit; the CPU's cmd becomes NOP the next cycle.
  - When the mask reaches 0 (including on the same edge as the final acks), go to ENABLE.
- **ENABLE:**
  - cbus_cmd_o[source] = EN_WR or EN_RD; all other cmds are NOP.
  - On cbus_ack_i[source], go to IDLE, pulse bcast_done_o for one cycle and set bcast_done_id_o to the captured id.
- Acks from CPUs not currently commanded (cmd NOP) are ignored in every state.
- cbus_addr_o: the captured address, held from SNOOP entry until the next capture, including while IDLE.
- bcast_done_id_o holds its last value between pulses.

## Timing
- Reset values:
  - State IDLE.
  - All cbus_cmd_o NOP; cbus_addr_o 0.
  - bcast_done_o 0; bcast_done_id_o 0.
  - bcast_ready_o 1 after reset release.
- Reset asserted mid-operation: cmds drop to NOP asynchronously; the in-flight broadcast is lost with no done pulse.
- All outputs are registered. ready is decoded from the state register.
- Latency, with accept at edge 0:
  - Snoop cmds visible in cycle 1.
  - Earliest acks sampled at edge 1.
  - Enable cmd visible in cycle 2; earliest enable ack at edge 2.
  - done and ready both high in cycle 3.
  - Minimum 3 cycles per broadcast; a back-to-back accept can occur at edge 3.
- Acks arriving in different cycles are accumulated independently. There is no timeout: the controller waits indefinitely.
- bcast_valid_i is a level; the controller consumes exactly one entry per valid&ready edge.

## Structure
- Shared package mesi_isc_pkg holds:
  - cbus command enum (NOP, WR_SNOOP, RD_SNOOP, EN_WR, EN_RD);
  - broadcast type enum (NOP, WR, RD);
  - CPU count (4) and width localparams;
  - FSM state enum.
- Single module, no sub-module: the pending mask is a 4-bit register inside the controller.

## Test plan
- **Basic write:** WR, cpu 0, id 5, addr 0x1000. CPUs 1–3 ack in cycle 1 → cmd[1..3]=WR_SNOOP in cycle 1 and cmd[0]=EN_WR in cycle 2. With cpu 0 ack at edge 2, done=1 with id 5 in cycle 3.
- **Staggered acks:** RD, cpu 2, id 9. CPUs 0, 1, 3 ack in cycles 1, 4, 2 → each cmd drops to NOP the cycle after its ack. cmd[2]=EN_RD first appears in cycle 5; ready stays 0 until the cycle after the enable ack.
- **Spurious ack:** during SNOOP for source 1, pulse cbus_ack_i[1] → ignored; source enable is still issued normally after the snoops complete.
- **NOP type:** type 0 with valid=1 → accepted (ready stays 1), all cmds NOP, no done pulse.
- **Reset mid-SNOOP:** drive rst=0 while cmd[3]=WR_SNOOP → cmd[3]=0 the same cycle, before any clock edge. After release, ready=1 and done stays 0.
- **Back-to-back:** two queued broadcasts (ids 1, 2) with immediate acks → done for id 1 in cycle 3 and id 2 in cycle 6.
